// File: rtl/fp32_argmax_stream_if.sv
// Score-in / result-out handshake bundle for fp32_argmax_stream.
// slave: the argmax block; master: score producer plus result consumer.
interface fp32_argmax_stream_if #(
  parameter int data_width = 32,
  parameter int idx_width  = 4
);
  logic                  in_valid;
  logic                  in_ready;
  logic [data_width-1:0] in_data;
  logic                  in_last;
  logic                  out_valid;
  logic                  out_ready;
  logic [idx_width-1:0]  out_index;
  logic [data_width-1:0] out_max;
  logic                  out_err;

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_index, out_max, out_err
  );

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_index, out_max, out_err
  );
endinterface

// File: rtl/fp32_argmax_stream.sv
// Streaming FP32 argmax: one score per beat, one result per frame.
// Ports: clk, reset (async high), bus (in_* scores, out_* index/max/err).
module fp32_argmax_stream #(
  parameter int data_width  = 32,
  parameter int num_classes = 10,
  parameter int idx_width   = 4
) (
  input logic                 clk,
  input logic                 reset,
  fp32_argmax_stream_if.slave bus
);
  typedef enum logic {COLLECT, HOLD} state_t;

  localparam logic [idx_width-1:0] last_cnt =
    idx_width'(num_classes - 1);

  // NaN never wins; any number beats a NaN; +0 and -0 tie.
  function automatic logic greater(
    input logic [data_width-1:0] a,
    input logic [data_width-1:0] b
  );
    logic a_nan, b_nan;
    a_nan = (&a[30:23]) && (|a[22:0]);
    b_nan = (&b[30:23]) && (|b[22:0]);
    if (a_nan)
      return 1'b0;
    else if (b_nan)
      return 1'b1;
    else if (a[31] != b[31])
      return (a[30:0] == '0 && b[30:0] == '0) ? 1'b0 : b[31];
    else if (!a[31])
      return a[30:0] > b[30:0];
    else
      return a[30:0] < b[30:0];
  endfunction

  state_t                state;
  logic [idx_width-1:0]  cnt;
  logic [idx_width-1:0]  cur_idx;
  logic [data_width-1:0] cur_max;
  logic                  err;
  logic                  in_ready_q;
  logic                  out_valid_q;

  logic last_beat;
  logic upd;
  logic beat_err;

  always_comb begin
    last_beat = (cnt == last_cnt);
    upd       = (cnt == '0) || greater(bus.in_data, cur_max);
    beat_err  = (bus.in_last != last_beat);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= COLLECT;
      cnt         <= '0;
      cur_idx     <= '0;
      cur_max     <= '0;
      err         <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      unique case (state)
        COLLECT: begin
          if (bus.in_valid) begin
            if (upd) begin
              cur_max <= bus.in_data;
              cur_idx <= cnt;
            end
            // error flag restarts with each frame's first beat
            err <= ((cnt == '0) ? 1'b0 : err) | beat_err;
            if (last_beat) begin
              cnt         <= '0;
              state       <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state       <= COLLECT;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: state <= COLLECT;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_index = cur_idx;
  assign bus.out_max   = cur_max;
  assign bus.out_err   = err;
endmodule

// File: tb/tb_fp32_argmax_stream.sv
// Scoreboard bench for fp32_argmax_stream with four-class frames.
// Directed frames push expectations; a negedge monitor pops and compares.
module tb_fp32_argmax_stream;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  typedef struct packed {
    logic [1:0]  idx;
    logic [31:0] mx;
    logic        err;
  } exp_t;

  exp_t q[$];

  fp32_argmax_stream_if #(.data_width(32), .idx_width(2)) bus ();

  fp32_argmax_stream #(
    .data_width(32),
    .num_classes(4),
    .idx_width(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Result consumer side: handshake completes on the next rising edge.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=%0d required=none",
                 bus.out_index);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("out_index", 32'(bus.out_index), 32'(e.idx));
        chk("out_max", bus.out_max, e.mx);
        chk("out_err", 32'(bus.out_err), 32'(e.err));
      end
    end
  end

  task automatic expect_res(input logic [1:0] idx,
                            input logic [31:0] mx,
                            input logic err);
    exp_t e;
    e.idx = idx;
    e.mx  = mx;
    e.err = err;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_beat(input logic [31:0] d, input logic last);
    int budget;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    budget = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      budget++;
      if (budget > 100) begin
        checks++;
        failures++;
        $display("FAIL beat_timeout actual=%0d required=1", bus.in_ready);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [3:0][31:0] d,
                            input logic [3:0] last_mask);
    for (int i = 0; i < 4; i++)
      send_beat(d[i], last_mask[i]);
  endtask

  initial begin
    logic [1:0]  s_idx;
    logic [31:0] s_max;
    logic        s_err;
    int          budget;

    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_index", 32'(bus.out_index), 32'd0);
    chk("rst_out_max", bus.out_max, 32'd0);
    chk("rst_out_err", 32'(bus.out_err), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(1);

    // basic positive frame, latency and single bubble
    expect_res(2'd2, 32'h40800000, 1'b0);
    send_frame({32'hBF800000, 32'h40800000,
                32'h404A1ADF, 32'h00000000}, 4'b1000);
    chk("lat_out_valid", 32'(bus.out_valid), 32'd1);
    chk("lat_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("bubble_in_ready", 32'(bus.in_ready), 32'd1);
    chk("bubble_out_valid", 32'(bus.out_valid), 32'd0);

    // negatives: -0 beats -1
    expect_res(2'd3, 32'h80000000, 1'b0);
    send_frame({32'h80000000, 32'hC0400000,
                32'hBF800000, 32'hC0000000}, 4'b1000);

    // tie keeps the earliest index
    expect_res(2'd1, 32'hBF800000, 1'b0);
    send_frame({32'hBF800000, 32'hC0400000,
                32'hBF800000, 32'hC0000000}, 4'b1000);

    // NaN never wins, -Inf loses to 1.0
    expect_res(2'd2, 32'h3F800000, 1'b0);
    send_frame({32'h7FC00000, 32'h3F800000,
                32'hFF800000, 32'h7FC00000}, 4'b1000);

    // all-NaN frame keeps the first pattern
    expect_res(2'd0, 32'h7FC00001, 1'b0);
    send_frame({32'h7FC00000, 32'hFFC00000,
                32'h7F800001, 32'h7FC00001}, 4'b1000);

    // +0 and -0 tie
    expect_res(2'd0, 32'h80000000, 1'b0);
    send_frame({32'hBF800000, 32'hBF800000,
                32'h00000000, 32'h80000000}, 4'b1000);

    // backpressure
    idle(1);
    bus.out_ready = 1'b0;
    expect_res(2'd1, 32'h41200000, 1'b0);
    send_frame({32'h3F800000, 32'h40000000,
                32'h41200000, 32'h3F000000}, 4'b1000);
    s_idx = bus.out_index;
    s_max = bus.out_max;
    s_err = bus.out_err;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h7F000000;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_out_index", 32'(bus.out_index), 32'(s_idx));
      chk("bp_out_max", bus.out_max, s_max);
      chk("bp_out_err", 32'(bus.out_err), 32'(s_err));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;

    // gapped frame: valid pattern 1,0,1,1,0,1
    expect_res(2'd3, 32'h40400000, 1'b0);
    send_beat(32'h3F800000, 1'b0);
    idle(1);
    send_beat(32'h40000000, 1'b0);
    send_beat(32'h3F000000, 1'b0);
    idle(1);
    send_beat(32'h40400000, 1'b1);

    // early in_last does not truncate
    expect_res(2'd3, 32'h40800000, 1'b1);
    send_frame({32'h40800000, 32'h40400000,
                32'h40000000, 32'h3F800000}, 4'b0010);
    // missing in_last on final beat
    expect_res(2'd0, 32'h40800000, 1'b1);
    send_frame({32'h3F800000, 32'h40000000,
                32'h40400000, 32'h40800000}, 4'b0000);
    // clean frame clears the flag
    expect_res(2'd2, 32'h40A00000, 1'b0);
    send_frame({32'h3F800000, 32'h40A00000,
                32'h40000000, 32'h3F800000}, 4'b1000);

    // async reset mid-frame
    idle(1);
    send_beat(32'h42000000, 1'b0);
    send_beat(32'h42000000, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk("arst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("arst_out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    expect_res(2'd1, 32'h40000000, 1'b0);
    send_frame({32'hBF800000, 32'h3F000000,
                32'h40000000, 32'h3F800000}, 4'b1000);

    budget = 0;
    while (q.size() != 0 && budget < 50) begin
      @(posedge clk);
      budget++;
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain actual=%0d required=0", q.size());
    end
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
